// File: rtl/sat_add_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : sat_add_pkg                                                    |
// | Description: Saturation helpers shared by the arbitrated saturating adder.  |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package sat_add_pkg;

  // Largest value representable in a signed field of out_width bits.
  function automatic int sat_max(input int out_width);
    return (1 << (out_width - 1)) - 1;
  endfunction

  // Smallest value representable in a signed field of out_width bits.
  function automatic int sat_min(input int out_width);
    return -(1 << (out_width - 1));
  endfunction

  // Clip a wide signed sum into out_width bits.
  // Returns {sat, value}; value is sign-extended to 32 bits so the caller
  // slices the low out_width bits.
  function automatic logic [32:0] sat_clip(input int sum, input int out_width);
    logic [32:0] res;
    if (sum > sat_max(out_width)) begin
      res = {1'b1, sat_max(out_width)};
    end else if (sum < sat_min(out_width)) begin
      res = {1'b1, sat_min(out_width)};
    end else begin
      res = {1'b0, sum};
    end
    return res;
  endfunction

endpackage : sat_add_pkg
`default_nettype wire

// File: rtl/sat_add_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : sat_add_arbiter_if                                             |
// | Description: Per-requester request channels and the shared response port.  |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface sat_add_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0][IN_WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][IN_WIDTH-1:0] req_b;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [ID_W-1:0]                  rsp_id;
  logic [OUT_WIDTH-1:0]             rsp_sum;
  logic                             rsp_sat;

  // Requesters plus the downstream consumer.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
  );

  // The shared adder.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
  );
endinterface : sat_add_arbiter_if
`default_nettype wire

// File: rtl/sat_add_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rr_arbiter                                                     |
// | Description: Round-robin grant; the pointer moves past the winner only     |
// |              when the grant is actually taken.                             |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst_b,
  input  wire logic [NUM_REQ-1:0]         req,
  input  wire logic                       advance,
  output logic      [NUM_REQ-1:0]         grant,
  output logic      [$clog2(NUM_REQ)-1:0] grant_idx
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] r_ptr;
  logic            w_found;
  int              w_idx;

  // Pick the first active request at or above the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = ID_W'(w_idx);
      end
    end
  end

  // Pointer lands just after the winner, and only when the transfer happens.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sat_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : sat_add_arbiter                                                |
// | Description: Round-robin shared two-stage signed saturating adder with     |
// |              tagged responses and a sticky saturation event counter.       |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module sat_add_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst_b,
  sat_add_arbiter_if.slave          bus,
  output logic      [CNT_WIDTH-1:0] sat_count
);
  import sat_add_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  // Stage payloads; widths follow the instance parameters, so they live here.
  typedef struct packed {
    logic [ID_W-1:0]            id;
    logic signed [IN_WIDTH-1:0] a;
    logic signed [IN_WIDTH-1:0] b;
  } s1_t;

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [OUT_WIDTH-1:0] sum;
    logic                 sat;
  } s2_t;

  logic                 r_s1_valid;
  s1_t                  r_s1;
  logic                 r_s2_valid;
  s2_t                  r_s2;
  logic [CNT_WIDTH-1:0] r_sat_count;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_accept;
  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_grant_idx;
  int                   w_sum;
  logic [32:0]          w_clip;
  logic                 w_unused_clip;

  // S2 frees up when empty or drained; S1 can move whenever S2 makes room.
  assign w_s2_adv = !r_s2_valid || bus.rsp_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_accept = (|bus.req_valid) && w_s1_adv;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_b     (rst_b),
    .req       (bus.req_valid),
    .advance   (w_s1_adv),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // Ready is the grant, gated only by whether S1 can take a new entry.
  assign bus.req_ready = w_grant & {NUM_REQ{w_s1_adv}};

  // Full-precision sum (never overflows 32 bits) then clip to OUT_WIDTH.
  assign w_sum         = int'($signed(r_s1.a)) + int'($signed(r_s1.b));
  assign w_clip        = sat_clip(w_sum, OUT_WIDTH);
  assign w_unused_clip = ^w_clip[31:OUT_WIDTH];

  // S1: capture the granted requester's operands and its index.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1.id <= w_grant_idx;
        r_s1.a  <= bus.req_a[w_grant_idx];
        r_s1.b  <= bus.req_b[w_grant_idx];
      end
    end
  end

  // S2: register the clipped result; held untouched while stalled.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2.id  <= r_s1.id;
        r_s2.sum <= w_clip[OUT_WIDTH-1:0];
        r_s2.sat <= w_clip[32];
      end
    end
  end

  // Count delivered saturated responses, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_sat_count <= '0;
    end else if (r_s2_valid && bus.rsp_ready && r_s2.sat && (r_sat_count != '1)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  assign bus.rsp_valid = r_s2_valid;
  assign bus.rsp_id    = r_s2.id;
  assign bus.rsp_sum   = r_s2.sum;
  assign bus.rsp_sat   = r_s2.sat;
  assign sat_count     = r_sat_count;

endmodule : sat_add_arbiter
`default_nettype wire

// File: tb/tb_sat_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_sat_add_arbiter                                             |
// | Description: Self-checking bench: directed scenarios plus random traffic   |
// |              compared against a queue-based reference model.               |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_sat_add_arbiter;
  localparam int N   = 4;
  localparam int IW  = 8;
  localparam int OW  = 4;
  localparam int CW  = 4;
  localparam int IDW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_b;
  logic [CW-1:0] sat_count;

  always #5 clk = ~clk;

  sat_add_arbiter_if #(.NUM_REQ(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  sat_add_arbiter #(
    .NUM_REQ   (N),
    .IN_WIDTH  (IW),
    .OUT_WIDTH (OW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus),
    .sat_count (sat_count)
  );

  typedef struct {
    int id;
    int sum;
    int sat;
  } exp_t;

  int           n_err = 0;
  int           n_chk = 0;
  exp_t         sb[$];
  logic [N-1:0] pend;
  logic [N-1:0] refill;
  int           pa[N];
  int           pb[N];
  int           rand_pct;
  int           ptr;
  int           inflight;
  int           sat_model;
  int           last_grant;
  int           n_acc;
  bit           obs_rv;
  bit           prev_stall;
  logic [IDW-1:0] prev_id;
  logic [OW-1:0]  prev_sum;
  logic           prev_sat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected response straight from the arithmetic rules.
  function automatic exp_t ref_rsp(input int id, input int a, input int b);
    exp_t e;
    int   s;
    int   mx;
    int   mn;
    s  = a + b;
    mx = (2 ** (OW - 1)) - 1;
    mn = -(2 ** (OW - 1));
    e.id = id;
    if (s > mx) begin
      e.sum = mx; e.sat = 1;
    end else if (s < mn) begin
      e.sum = mn; e.sat = 1;
    end else begin
      e.sum = s;  e.sat = 0;
    end
    return e;
  endfunction

  task automatic new_ops(input int i);
    if ($urandom_range(1) == 1) begin
      pa[i] = int'($urandom_range(255)) - 128;
      pb[i] = int'($urandom_range(255)) - 128;
    end else begin
      pa[i] = int'($urandom_range(14)) - 7;
      pb[i] = int'($urandom_range(14)) - 7;
    end
  endtask

  task automatic clear_model();
    sb.delete();
    inflight   = 0;
    ptr        = 0;
    sat_model  = 0;
    prev_stall = 1'b0;
  endtask

  // One clock: drive, check at the falling edge, update the model, advance.
  task automatic drive_cycle(input bit rdy);
    bit           exp_acc;
    int           exp_idx;
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_a[i]     = IW'(pa[i]);
      bus.req_b[i]     = IW'(pb[i]);
    end
    bus.rsp_ready = rdy;
    @(negedge clk);
    // Two items in flight means both stages are occupied.
    exp_acc   = (pend != '0) && !(inflight == 2 && !rdy);
    exp_idx   = -1;
    exp_ready = '0;
    if (exp_acc) begin
      for (int k = 0; k < N; k++) begin
        if (exp_idx < 0 && pend[(ptr + k) % N]) exp_idx = (ptr + k) % N;
      end
      exp_ready[exp_idx] = 1'b1;
    end
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("sat_count", 32'(sat_count), 32'(sat_model));
    obs_rv = bus.rsp_valid;
    if (inflight == 0) check("rsp_idle", 32'(bus.rsp_valid), 32'd0);
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_extra", 32'd1, 32'd0);
      end else begin
        check("rsp_id",  32'(bus.rsp_id),  32'(sb[0].id));
        check("rsp_sum", 32'(bus.rsp_sum), sb[0].sum & ((1 << OW) - 1));
        check("rsp_sat", 32'(bus.rsp_sat), 32'(sb[0].sat));
        if (prev_stall) begin
          check("hold_id",  32'(bus.rsp_id),  32'(prev_id));
          check("hold_sum", 32'(bus.rsp_sum), 32'(prev_sum));
          check("hold_sat", 32'(bus.rsp_sat), 32'(prev_sat));
        end
        if (rdy) begin
          if (sb[0].sat == 1 && sat_model < (2 ** CW) - 1) sat_model++;
          void'(sb.pop_front());
          inflight--;
        end
      end
    end
    prev_stall = bus.rsp_valid && !rdy;
    prev_id    = bus.rsp_id;
    prev_sum   = bus.rsp_sum;
    prev_sat   = bus.rsp_sat;
    last_grant = -1;
    if (exp_acc) begin
      sb.push_back(ref_rsp(exp_idx, pa[exp_idx], pb[exp_idx]));
      inflight++;
      n_acc++;
      ptr           = (exp_idx + 1) % N;
      last_grant    = exp_idx;
      pend[exp_idx] = 1'b0;
      if (refill[exp_idx]) begin
        pend[exp_idx] = 1'b1;
        new_ops(exp_idx);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && rand_pct > 0 && int'($urandom_range(99)) < rand_pct) begin
        pend[i] = 1'b1;
        new_ops(i);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    pend     = '0;
    refill   = '0;
    rand_pct = 0;
    done     = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!done && sb.size() == 0) done = 1'b1;
      if (!done) drive_cycle(1'b1);
    end
    if (!done) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Reset while idle; called at posedge+1.
  task automatic do_reset();
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    clear_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int ca[4] = '{100, -100, 127, -3};
  int cb[4] = '{27, -28, 127, 2};
  int fo[4] = '{0, 2, 3, 0};

  initial begin
    rst_b         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    pend     = '0;
    refill   = '0;
    rand_pct = 0;
    n_acc    = 0;
    for (int i = 0; i < N; i++) begin pa[i] = 0; pb[i] = 0; end
    clear_model();

    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    check("rst_rsp_sum",   32'(bus.rsp_sum),   32'd0);
    check("rst_rsp_sat",   32'(bus.rsp_sat),   32'd0);
    check("rst_sat_count", 32'(sat_count),     32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_b = 1'b1;

    // Single request on port 2 with latency check.
    pend[2] = 1'b1; pa[2] = 5; pb[2] = 1;
    drive_cycle(1'b1);
    check("single_grant", 32'(last_grant), 32'd2);
    drive_cycle(1'b1);
    check("single_lat1", 32'(obs_rv), 32'd0);
    drive_cycle(1'b1);
    check("single_lat2", 32'(obs_rv), 32'd1);
    drain();

    // Clip cases one at a time on port 0.
    for (int k = 0; k < 4; k++) begin
      pend[0] = 1'b1; pa[0] = ca[k]; pb[0] = cb[k];
      drive_cycle(1'b1);
      drain();
    end
    check("clip_sat_count", 32'(sat_count), 32'd3);

    // Fairness from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) new_ops(i);
    pend = '1; refill = '1;
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b1);
      check("fair_all", 32'(last_grant), 32'(k % N));
    end
    pend[1] = 1'b0; refill = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1);
      check("fair_drop1", 32'(last_grant), 32'(fo[k]));
    end
    drain();

    // Backpressure from an empty pipe: two accepts then stall.
    for (int i = 0; i < N; i++) new_ops(i);
    pend = '1; refill = '1; n_acc = 0;
    for (int k = 0; k < 5; k++) drive_cycle(1'b0);
    check("bp_accepts", 32'(n_acc), 32'd2);
    check("bp_ready_low", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < 8; k++) drive_cycle(1'b1);
    drain();

    // Reset with both stages full.
    for (int i = 0; i < N; i++) new_ops(i);
    pend = '1; refill = '1;
    for (int k = 0; k < 3; k++) drive_cycle(1'b0);
    rst_b = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_sat_count", 32'(sat_count), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    clear_model();
    refill = '0;
    pend = 4'b0110;
    drive_cycle(1'b1);
    check("midrst_first_grant", 32'(last_grant), 32'd1);
    drain();

    // Counter stick: 20 saturating requests.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      pend[3] = 1'b1; pa[3] = 100; pb[3] = 100;
      drive_cycle(1'b1);
    end
    drain();
    check("stick_sat_count", 32'(sat_count), 32'd15);

    // Random traffic with random backpressure.
    do_reset();
    rand_pct = 50;
    for (int k = 0; k < 400; k++) drive_cycle($urandom_range(3) != 0);
    drain();
    check("rand_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_sat_add_arbiter
`default_nettype wire
